// File: rtl/if_id_hazard_ctrl.sv
// rtl/if_id_hazard_ctrl.sv - IF/ID hazard, redirect-flush and fetch-wait sequencer with perf counters
module if_id_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_WAIT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic                  rs1_used_ID,
    input  logic                  rs2_used_ID,
    input  logic [REG_ADDR_W-1:0] rd_EX,
    input  logic                  mem_read_EX,
    input  logic                  YAGS_conflict,
    input  logic                  jump_instruction_EX,
    input  logic                  imem_ready,
    input  logic                  perf_clear,
    output logic                  PC_write_en,
    output logic                  IF_ID_reg_write_en,
    output logic                  IF_ID_flush,
    output logic                  ID_EX_bubble,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      load_use_cnt,
    output logic                  timeout_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          fl_cnt_q, fl_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]    load_use_cnt_q, load_use_cnt_d;
    logic                timeout_err_q, timeout_err_d;

    logic redirect;
    logic lu_hazard;
    logic pc_we_c, ifid_we_c, ifid_flush_c, bubble_c, lu_event;

    assign redirect  = YAGS_conflict | jump_instruction_EX;
    assign lu_hazard = mem_read_EX && (rd_EX != '0) &&
                       ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                        (rs2_used_ID && (rs2_ID == rd_EX)));

    always_comb begin
        state_d      = state_q;
        fl_cnt_d     = fl_cnt_q;
        wait_cnt_d   = '0;
        pc_we_c      = 1'b0;
        ifid_we_c    = 1'b0;
        ifid_flush_c = 1'b0;
        bubble_c     = 1'b0;
        lu_event     = 1'b0;
        if (redirect) begin
            // PC loads the target now; wrong-path slots are squashed afterwards
            pc_we_c      = 1'b1;
            ifid_flush_c = 1'b1;
            bubble_c     = 1'b1;
            fl_cnt_d     = 3'(FLUSH_CYCLES);
            state_d      = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    pc_we_c      = 1'b1;
                    ifid_flush_c = 1'b1;
                    bubble_c     = 1'b1;
                    if (fl_cnt_q <= 3'd1) begin
                        state_d  = ST_RUN;
                        fl_cnt_d = 3'd0;
                    end else begin
                        fl_cnt_d = fl_cnt_q - 3'd1;
                    end
                end
                ST_RUN, ST_WAIT: begin
                    if (lu_hazard && (state_q == ST_RUN)) begin
                        bubble_c = 1'b1;
                        lu_event = 1'b1;
                        state_d  = ST_RUN;
                    end else if (!imem_ready) begin
                        ifid_flush_c = 1'b1;
                        state_d      = ST_WAIT;
                        wait_cnt_d   = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ?
                                       wait_cnt_q : wait_cnt_q + 1'b1;
                    end else begin
                        pc_we_c   = 1'b1;
                        ifid_we_c = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
                default: begin
                    ifid_flush_c = 1'b1;
                    bubble_c     = 1'b1;
                    state_d      = ST_RUN;
                    fl_cnt_d     = 3'd0;
                end
            endcase
        end
    end

    // Front end is frozen and squashed for as long as reset is held
    assign PC_write_en        = reset & pc_we_c;
    assign IF_ID_reg_write_en = reset & ifid_we_c;
    assign IF_ID_flush        = ~reset | ifid_flush_c;
    assign ID_EX_bubble       = ~reset | bubble_c;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        load_use_cnt_d = load_use_cnt_q;
        timeout_err_d  = timeout_err_q | (wait_cnt_d == WAIT_W'(MAX_WAIT));
        if (perf_clear) begin
            stall_cnt_d    = '0;
            flush_cnt_d    = '0;
            load_use_cnt_d = '0;
        end else begin
            if (!PC_write_en && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (redirect && (flush_cnt_q != '1))
                flush_cnt_d = flush_cnt_q + 1'b1;
            if (lu_event && (load_use_cnt_q != '1))
                load_use_cnt_d = load_use_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            fl_cnt_q       <= 3'd0;
            wait_cnt_q     <= '0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
            load_use_cnt_q <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            fl_cnt_q       <= fl_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            load_use_cnt_q <= load_use_cnt_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign state_o      = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign load_use_cnt = load_use_cnt_q;
    assign timeout_err  = timeout_err_q;

endmodule
